ase_sim_local_mem_avmm_arbiter: RTL and testbench
=================================================

ASE_SIM_LOCAL_MEM_AVMM_ARBITER -- requirements
Module: ase_sim_local_mem_avmm_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 27: word address width.
REQ-002 Parameter DATA_WIDTH, default 512: data beat width; BE_WIDTH = DATA_WIDTH/8.
REQ-003 Parameter BURST_CNT_WIDTH, default 7: burstcount width.
REQ-004 Parameter RSP_FIFO_DEPTH, default 16, power of 2: outstanding read commands tracked.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 sN_waitrequest  output  1  per requester N in {0,1}; command stall.
REQ-008 sN_readdata  output  DATA_WIDTH  read data to requester N.
REQ-009 sN_readdatavalid  output  1  read beat valid for requester N.
REQ-010 sN_address / sN_burstcount / sN_writedata / sN_byteenable  input  ADDR_WIDTH / BURST_CNT_WIDTH / DATA_WIDTH / BE_WIDTH  requester N command fields.
REQ-011 sN_read, sN_write  input  1  requester N command strobes; never both high.
REQ-012 m_waitrequest, m_readdatavalid  input  1; m_readdata  input  DATA_WIDTH: shared memory bank responses.
REQ-013 m_address, m_burstcount, m_writedata, m_byteenable, m_read, m_write  output  widths as REQ-010/011: shared bank command.

Function
REQ-014 Block SHALL share one Avalon-MM memory bank between requesters 0 and 1; command path combinational from granted requester to m_*, zero added latency.
REQ-015 FSM states SHALL be ARB and WR_BURST.
REQ-016 In ARB, grant SHALL go to the requesting port (read or write high) not granted last; sole requester wins; none requesting -> m_read=m_write=0.
REQ-017 Non-granted port SHALL see waitrequest=1; granted port SHALL see m_waitrequest, plus forced 1 when it issues a read and RSP FIFO is full.
REQ-018 Read accepted (m_read & ~m_waitrequest) SHALL push {port id, burstcount} into RSP FIFO and mark that port last-granted; FSM stays ARB.
REQ-019 Write beat accepted in ARB with burstcount>1 SHALL load beat counter = burstcount-1 and enter WR_BURST locked to that port; burstcount==1 completes in ARB and updates last-granted.
REQ-020 In WR_BURST, only locked port SHALL drive m_*; counter decrements per accepted beat; at counter==1 with beat accepted -> ARB, last-granted = locked port. Other port's requests SHALL stall regardless of priority.
REQ-021 burstcount 0 SHALL be treated as 1.
REQ-022 Each m_readdatavalid SHALL route to FIFO-head port's sN_readdatavalid; head remaining-beat count decrements; pop at last beat. sN_readdata = m_readdata for both ports.
REQ-023 Read responses SHALL return in command order across ports; no reordering.
REQ-024 FIFO full determined at cycle start: push on full prohibited even with same-cycle pop; pop and push in same non-full cycle both occur.
REQ-025 m_readdatavalid with FIFO empty SHALL be dropped (no sN_readdatavalid) and flagged by a simulation assertion.
REQ-026 Writes SHALL never stall on FIFO full.

Reset
REQ-027 reset_n low SHALL immediately force: FSM=ARB, last-granted=1 (port 0 favoured first), beat counter=0, FIFO empty, m_read=m_write=0, s0/s1_waitrequest=1, s0/s1_readdatavalid=0.
REQ-028 Reset mid-burst or with reads outstanding SHALL discard all state; responses arriving after release with empty FIFO follow REQ-025.
REQ-029 Outputs SHALL stay at reset values until first clk edge after reset_n rises.

Verification
REQ-030 Both ports read burstcount=1 continuously, m_waitrequest=0 -> grants alternate 0,1,0,1; first grant port 0.
REQ-031 Port 0 write burstcount=4 with port 1 read pending, m_waitrequest toggling -> exactly 4 port-0 beats on m_*, port 1 waitrequest=1 throughout, port 1 read issued next cycle after last beat.
REQ-032 Port 0 read bc=2 then port 1 read bc=3, memory returns 5 beats -> s0_readdatavalid beats 1-2, s1_readdatavalid beats 3-5, FIFO empty after.
REQ-033 16 reads outstanding, no responses -> FIFO full, next read waitrequest=1, concurrent write bc=1 still accepted; one response pop -> read accepted next cycle.
REQ-034 reset_n asserted during beat 2 of bc=8 write -> m_write=0 same cycle, FSM ARB, waitrequest=1; after release new port-1-only write accepted normally.
REQ-035 m_readdatavalid with no outstanding read -> no sN_readdatavalid, assertion fires.

Source files
------------

// File: rtl/ase_sim_local_mem_avmm_arbiter.sv
// ase_sim_local_mem_avmm_arbiter
// Shares one Avalon-MM memory bank between two requesters (s0, s1).
// Commands pass combinationally from the granted requester to m_*; write
// bursts lock the grant until their last beat; read responses are routed
// back in command order through a small FIFO of {port, beats} records.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   sN_address/burstcount/writedata/byteenable/read/write   requester N cmd
//   sN_waitrequest, sN_readdata, sN_readdatavalid           requester N rsp
//   m_address/burstcount/writedata/byteenable/read/write    bank command
//   m_waitrequest, m_readdata, m_readdatavalid              bank response
module ase_sim_local_mem_avmm_arbiter #(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int RSP_FIFO_DEPTH  = 16,
    localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       reset_n,

    output logic                       s0_waitrequest,
    output logic [DATA_WIDTH-1:0]      s0_readdata,
    output logic                       s0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]      s0_address,
    input  logic [BURST_CNT_WIDTH-1:0] s0_burstcount,
    input  logic [DATA_WIDTH-1:0]      s0_writedata,
    input  logic [BE_WIDTH-1:0]        s0_byteenable,
    input  logic                       s0_read,
    input  logic                       s0_write,

    output logic                       s1_waitrequest,
    output logic [DATA_WIDTH-1:0]      s1_readdata,
    output logic                       s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]      s1_address,
    input  logic [BURST_CNT_WIDTH-1:0] s1_burstcount,
    input  logic [DATA_WIDTH-1:0]      s1_writedata,
    input  logic [BE_WIDTH-1:0]        s1_byteenable,
    input  logic                       s1_read,
    input  logic                       s1_write,

    input  logic                       m_waitrequest,
    input  logic [DATA_WIDTH-1:0]      m_readdata,
    input  logic                       m_readdatavalid,
    output logic [ADDR_WIDTH-1:0]      m_address,
    output logic [BURST_CNT_WIDTH-1:0] m_burstcount,
    output logic [DATA_WIDTH-1:0]      m_writedata,
    output logic [BE_WIDTH-1:0]        m_byteenable,
    output logic                       m_read,
    output logic                       m_write
);

    localparam int PW = $clog2(RSP_FIFO_DEPTH);
    localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE  = BURST_CNT_WIDTH'(1);
    localparam logic [PW:0]                PTR_ONE = (PW + 1)'(1);

    typedef enum logic {ARB, WR_BURST} state_t;

    state_t                     state_q, state_d;
    logic                       last_q, last_d;   // port granted last
    logic                       lock_q, lock_d;   // port owning the write burst
    logic [BURST_CNT_WIDTH-1:0] beat_q, beat_d;   // beats left in the burst
    logic                       out_en_q;         // low from reset until first edge after release

    logic                       fifo_port [RSP_FIFO_DEPTH];
    logic [BURST_CNT_WIDTH-1:0] fifo_cnt  [RSP_FIFO_DEPTH];
    logic [PW:0]                wr_ptr, rd_ptr;
    logic                       fifo_full, fifo_empty;
    logic                       head_port;
    logic [BURST_CNT_WIDTH-1:0] head_cnt;

    logic                       grant, gvalid;
    logic                       sel_read, sel_write;
    logic [BURST_CNT_WIDTH-1:0] sel_bc, bc_eff;
    logic                       rd_block, granted_wait;
    logic                       rd_acc, wr_acc, rsp_valid, pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head_port  = fifo_port[rd_ptr[PW-1:0]];
    assign head_cnt   = fifo_cnt[rd_ptr[PW-1:0]];

    // Grant selection: locked port during a burst, otherwise round-robin.
    always_comb begin
        grant  = 1'b0;
        gvalid = 1'b0;
        if (state_q == WR_BURST) begin
            grant  = lock_q;
            gvalid = 1'b1;
        end else if ((s0_read | s0_write) && (s1_read | s1_write)) begin
            grant  = ~last_q;
            gvalid = 1'b1;
        end else if (s0_read | s0_write) begin
            gvalid = 1'b1;
        end else if (s1_read | s1_write) begin
            grant  = 1'b1;
            gvalid = 1'b1;
        end
    end

    assign sel_read  = grant ? s1_read       : s0_read;
    assign sel_write = grant ? s1_write      : s0_write;
    assign sel_bc    = grant ? s1_burstcount : s0_burstcount;
    assign bc_eff    = (sel_bc == '0) ? BC_ONE : sel_bc;

    assign m_address    = grant ? s1_address    : s0_address;
    assign m_burstcount = sel_bc;
    assign m_writedata  = grant ? s1_writedata  : s0_writedata;
    assign m_byteenable = grant ? s1_byteenable : s0_byteenable;

    // A read is held off when no response slot is free (full sampled at cycle
    // start) or when a write burst owns the bus.
    assign rd_block     = sel_read & (fifo_full | (state_q == WR_BURST));
    assign m_read       = out_en_q & gvalid & sel_read & ~rd_block;
    assign m_write      = out_en_q & gvalid & sel_write;
    assign granted_wait = m_waitrequest | rd_block;

    assign s0_waitrequest = (out_en_q && gvalid && !grant) ? granted_wait : 1'b1;
    assign s1_waitrequest = (out_en_q && gvalid &&  grant) ? granted_wait : 1'b1;

    assign rd_acc = m_read  & ~m_waitrequest;
    assign wr_acc = m_write & ~m_waitrequest;

    // Responses with nothing outstanding are dropped.
    assign rsp_valid        = out_en_q & m_readdatavalid & ~fifo_empty;
    assign pop              = rsp_valid & (head_cnt == BC_ONE);
    assign s0_readdatavalid = rsp_valid & ~head_port;
    assign s1_readdatavalid = rsp_valid &  head_port;
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        lock_d  = lock_q;
        beat_d  = beat_q;
        case (state_q)
            ARB: begin
                if (rd_acc) begin
                    last_d = grant;
                end else if (wr_acc) begin
                    if (bc_eff > BC_ONE) begin
                        beat_d  = bc_eff - BC_ONE;
                        lock_d  = grant;
                        state_d = WR_BURST;
                    end else begin
                        last_d = grant;
                    end
                end
            end
            WR_BURST: begin
                if (wr_acc) begin
                    if (beat_q == BC_ONE) begin
                        beat_d  = '0;
                        last_d  = lock_q;
                        state_d = ARB;
                    end else begin
                        beat_d = beat_q - BC_ONE;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB;
            last_q   <= 1'b1;
            lock_q   <= 1'b0;
            beat_q   <= '0;
            out_en_q <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            lock_q   <= lock_d;
            beat_q   <= beat_d;
            out_en_q <= 1'b1;
            if (rd_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
            assert (!(m_readdatavalid && fifo_empty))
                else $warning("m_readdatavalid with no outstanding read; beat dropped");
        end
    end

    // Record storage needs no reset: only the pointers define validity.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            fifo_port[wr_ptr[PW-1:0]] <= grant;
            fifo_cnt[wr_ptr[PW-1:0]]  <= bc_eff;
        end
        if (rsp_valid && !pop)
            fifo_cnt[rd_ptr[PW-1:0]] <= head_cnt - BC_ONE;
    end

endmodule

// File: tb/tb_ase_sim_local_mem_avmm_arbiter.sv
module tb_ase_sim_local_mem_avmm_arbiter;

    localparam int AW = 27, DW = 512, BCW = 7, BEW = DW / 8, DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic [1:0]     s_read, s_write;
    logic [AW-1:0]  s_addr  [2];
    logic [BCW-1:0] s_bc    [2];
    logic [DW-1:0]  s_wdata [2];
    logic [BEW-1:0] s_be    [2];
    logic           s0_wt, s1_wt, s0_rv, s1_rv;
    logic [DW-1:0]  rd0, rd1;
    logic           m_wait, m_rdv;
    logic [DW-1:0]  m_rdata;
    logic [AW-1:0]  m_address;
    logic [BCW-1:0] m_burstcount;
    logic [DW-1:0]  m_writedata;
    logic [BEW-1:0] m_byteenable;
    logic           m_read, m_write;

    ase_sim_local_mem_avmm_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW), .RSP_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_waitrequest(s0_wt), .s0_readdata(rd0), .s0_readdatavalid(s0_rv),
        .s0_address(s_addr[0]), .s0_burstcount(s_bc[0]), .s0_writedata(s_wdata[0]),
        .s0_byteenable(s_be[0]), .s0_read(s_read[0]), .s0_write(s_write[0]),
        .s1_waitrequest(s1_wt), .s1_readdata(rd1), .s1_readdatavalid(s1_rv),
        .s1_address(s_addr[1]), .s1_burstcount(s_bc[1]), .s1_writedata(s_wdata[1]),
        .s1_byteenable(s_be[1]), .s1_read(s_read[1]), .s1_write(s_write[1]),
        .m_waitrequest(m_wait), .m_readdata(m_rdata), .m_readdatavalid(m_rdv),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_read(m_read), .m_write(m_write)
    );

    // Reference model: ordered list of outstanding read bursts, round-robin
    // owner, and the write burst currently holding the bus.
    typedef struct packed { int port; int beats; } rsp_t;
    rsp_t rq[$];
    int   last_g = 1;
    bit   lock_on = 0;
    int   lock_port = 0, lock_left = 0;
    bit   en = 0;

    // Requester behaviour: hold a command until accepted; write bursts run to completion.
    int pend [2] = '{0, 0};   // 0 idle, 1 read, 2 write
    int mleft[2] = '{0, 0};

    // Stimulus knobs
    int p_new = 0, p_rd = 50, p_wait = 0, p_rsp = 0, bc_max = 4, bc_fix = -1;
    bit port_ok[2] = '{1, 1};
    bit force_rdv = 0;
    bit rst_next = 0;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic new_beat(input int p);
        s_wdata[p] = rnd_data();
        s_be[p]    = {$urandom, $urandom};
    endtask

    task automatic issue(input int p, input int kind, input int bc);
        pend[p]   = kind;
        s_bc[p]   = BCW'(bc);
        mleft[p]  = (bc == 0) ? 1 : bc;
        s_addr[p] = AW'($urandom);
        new_beat(p);
    endtask

    task automatic gen_stim();
        reset_n = rst_next;
        for (int p = 0; p < 2; p++) begin
            if (pend[p] == 0 && port_ok[p] && $urandom_range(99) < p_new)
                issue(p, ($urandom_range(99) < p_rd) ? 1 : 2,
                      (bc_fix >= 0) ? bc_fix : $urandom_range(bc_max));
            s_read[p]  = (pend[p] == 1);
            s_write[p] = (pend[p] == 2);
        end
        m_wait  = ($urandom_range(99) < p_wait);
        m_rdv   = force_rdv || (rq.size() > 0 && $urandom_range(99) < p_rsp);
        m_rdata = rnd_data();
    endtask

    task automatic check_cycle();
        bit gv, er, ew, full;
        bit [1:0] ewt, erdv;
        int g, bce;
        gv = 0; g = 0; er = 0; ew = 0; ewt = 2'b11; erdv = 2'b00;
        full = (rq.size() >= DEPTH);
        if (reset_n && en) begin
            if (lock_on) begin
                gv = 1; g = lock_port;
            end else if ((s_read[0] | s_write[0]) && (s_read[1] | s_write[1])) begin
                gv = 1; g = 1 - last_g;
            end else if (s_read[0] | s_write[0]) begin
                gv = 1; g = 0;
            end else if (s_read[1] | s_write[1]) begin
                gv = 1; g = 1;
            end
            if (gv) begin
                er     = s_read[g] && !full && !lock_on;
                ew     = s_write[g];
                ewt[g] = m_wait || (s_read[g] && (full || lock_on));
            end
            if (m_rdv && rq.size() > 0) erdv[rq[0].port] = 1'b1;
        end
        chk("m_read",  DW'(m_read),  DW'(er));
        chk("m_write", DW'(m_write), DW'(ew));
        chk("s0_waitrequest", DW'(s0_wt), DW'(ewt[0]));
        chk("s1_waitrequest", DW'(s1_wt), DW'(ewt[1]));
        chk("s0_readdatavalid", DW'(s0_rv), DW'(erdv[0]));
        chk("s1_readdatavalid", DW'(s1_rv), DW'(erdv[1]));
        if (er || ew) begin
            chk("m_address",    DW'(m_address),    DW'(s_addr[g]));
            chk("m_burstcount", DW'(m_burstcount), DW'(s_bc[g]));
        end
        if (ew) begin
            chk("m_writedata",  m_writedata,        s_wdata[g]);
            chk("m_byteenable", DW'(m_byteenable),  DW'(s_be[g]));
        end
        if (erdv[0]) chk("s0_readdata", rd0, m_rdata);
        if (erdv[1]) chk("s1_readdata", rd1, m_rdata);

        if (!reset_n) begin
            rq.delete();
            lock_on = 0; lock_left = 0; last_g = 1; en = 0;
            pend = '{0, 0};
            return;
        end
        bce = (s_bc[g] == 0) ? 1 : int'(s_bc[g]);
        if (er && !m_wait) begin
            rq.push_back('{port: g, beats: bce});
            last_g  = g;
            pend[g] = 0;
        end
        if (ew && !m_wait) begin
            if (lock_on) begin
                lock_left--;
                if (lock_left == 0) begin
                    lock_on = 0;
                    last_g  = lock_port;
                end
            end else if (bce > 1) begin
                lock_on = 1; lock_port = g; lock_left = bce - 1;
            end else begin
                last_g = g;
            end
            mleft[g]--;
            if (mleft[g] == 0) pend[g] = 0;
            else new_beat(g);
        end
        if (erdv != 2'b00) begin
            rq[0].beats--;
            if (rq[0].beats == 0) void'(rq.pop_front());
        end
        en = 1;
    endtask

    task automatic tick();
        @(negedge clk);
        gen_stim();
        #1;
        check_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Let every outstanding command and response complete.
    task automatic drain();
        int k;
        p_new = 0; p_rsp = 100; p_wait = 0; k = 0;
        while ((pend[0] != 0 || pend[1] != 0 || rq.size() != 0 || lock_on) && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) chk("drain_timeout", DW'(1), DW'(0));
    endtask

    task automatic wait_done(input int p, input string tag);
        int k;
        k = 0;
        while (pend[p] != 0 && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) chk(tag, DW'(1), DW'(0));
    endtask

    initial begin
        reset_n = 1'b0; rst_next = 0;
        s_read = '0; s_write = '0;
        for (int p = 0; p < 2; p++) begin
            s_addr[p] = '0; s_bc[p] = '0; s_wdata[p] = '0; s_be[p] = '0;
        end
        m_wait = 0; m_rdv = 0; m_rdata = '0;

        // Reset values, including with requests present; then alternating reads.
        p_new = 100; p_rd = 100; bc_fix = 1; p_rsp = 100;
        run(3);
        rst_next = 1;
        run(20);

        // Port 0 write burst of 4 with port 1 read pending, toggling waitrequest.
        drain();
        issue(0, 2, 4);
        tick();
        issue(1, 1, 1);
        p_wait = 50;
        wait_done(0, "burst4_timeout");
        wait_done(1, "read_after_burst_timeout");
        drain();

        // Read bc=2 on port 0 then bc=3 on port 1; responses routed in order.
        p_rsp = 0;
        issue(0, 1, 2);
        wait_done(0, "rd0_timeout");
        issue(1, 1, 3);
        wait_done(1, "rd1_timeout");
        p_rsp = 100;
        run(8);

        // Fill the response FIFO, write still accepted, one pop frees a slot.
        drain();
        p_rsp = 0; p_new = 100; p_rd = 100; bc_fix = 1; port_ok = '{1, 0};
        run(20);
        issue(1, 2, 1);
        run(3);
        p_rsp = 100; tick(); p_rsp = 0;
        run(3);
        port_ok = '{1, 1};
        drain();

        // Reset during beat 2 of an 8-beat write, then a port-1-only write.
        issue(0, 2, 8);
        begin
            int k;
            k = 0;
            while (!(lock_on && lock_left == 7) && k < 50) begin
                tick();
                k++;
            end
            if (k >= 50) chk("burst8_timeout", DW'(1), DW'(0));
        end
        rst_next = 0;
        run(2);
        rst_next = 1;
        tick();
        force_rdv = 1; tick(); force_rdv = 0;   // stray response after reset is dropped
        issue(1, 2, 3);
        wait_done(1, "post_reset_write_timeout");

        // Randomized traffic, burstcount 0 included.
        p_new = 40; p_rd = 50; bc_fix = -1; bc_max = 4; p_wait = 30; p_rsp = 40;
        run(3000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
